// File: rtl/mc_pkg.sv
// Shared constants, FSM encoding and the fixed-point step arithmetic for the
// binomial path generator.
package mc_pkg;

    localparam int W    = 12;
    localparam int FRAC = 8;

    localparam logic [W-1:0] ONE       = 12'h100;
    localparam logic [15:0]  LFSR_SEED = 16'hACE1;

    localparam int TAP_A = 15;
    localparam int TAP_B = 13;
    localparam int TAP_C = 12;
    localparam int TAP_D = 10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EMIT,
        ST_GAP,
        ST_DONE
    } state_t;

    // S * factor in Q4.8, saturating at all-ones and never collapsing to zero,
    // so a path can always recover from its floor.
    function automatic logic [W-1:0] mc_step(input logic [W-1:0] s, input logic [W-1:0] f);
        logic [2*W-1:0] prod;
        logic [2*W-1:0] sh;
        logic [W-1:0]   nxt;
        prod = {{W{1'b0}}, s} * {{W{1'b0}}, f};
        sh   = prod >> FRAC;
        nxt  = sh[W-1:0];
        if (sh[2*W-1:W] != '0) begin
            nxt = '1;
        end
        if (nxt == '0) begin
            nxt = {{(W-1){1'b0}}, 1'b1};
        end
        return nxt;
    endfunction

endpackage

// File: rtl/mc_lfsr16.sv
// 16-bit Fibonacci LFSR with a load port used for both seeding and
// restoring a path snapshot; load takes priority over stepping.
module mc_lfsr16
    import mc_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        step_en,
    input  logic        load,
    input  logic [15:0] load_val,
    output logic [15:0] lfsr,
    output logic        fb
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    assign fb   = lfsr_q[TAP_A] ^ lfsr_q[TAP_B] ^ lfsr_q[TAP_C] ^ lfsr_q[TAP_D];
    assign lfsr = lfsr_q;

    always_comb begin
        lfsr_d = lfsr_q;
        if (load) begin
            lfsr_d = load_val;
        end else if (step_en) begin
            lfsr_d = {lfsr_q[14:0], fb};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

endmodule

// File: rtl/mc_path_gen.sv
// Binomial-tree price-path producer: PATHS paths of STEPS+1 samples, one per
// cycle, with bit-exact replay of the current path on resend.
module mc_path_gen #(
    parameter int             W     = 12,
    parameter int             FRAC  = 8,
    parameter int             STEPS = 64,
    parameter int             PATHS = 256,
    parameter logic [W-1:0]   S0    = W'(1) << FRAC,
    parameter logic [W-1:0]   UP    = 12'h10A,
    parameter logic [W-1:0]   DN    = 12'h0F7,
    localparam int            IW    = (PATHS > 1) ? $clog2(PATHS) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          resend,
    input  logic [15:0]   seed,
    output logic          path_valid,
    output logic [W-1:0]  path,
    output logic          path_last,
    output logic [IW-1:0] path_idx,
    output logic          busy,
    output logic          done
);
    import mc_pkg::*;

    localparam int            CW     = $clog2(STEPS + 1);
    localparam logic [CW-1:0] LAST_K = CW'(STEPS);
    localparam logic [IW-1:0] LAST_P = IW'(PATHS - 1);

    state_t        state_q, state_d;
    logic          path_valid_q, path_valid_d;
    logic [W-1:0]  path_q, path_d;
    logic          path_last_q, path_last_d;
    logic [IW-1:0] path_idx_q, path_idx_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [15:0]   snap_q, snap_d;
    logic [CW-1:0] step_q, step_d;

    logic          lfsr_step;
    logic          lfsr_load;
    logic [15:0]   lfsr_load_val;
    logic [15:0]   lfsr_cur;
    logic          fb;
    logic [15:0]   seed_eff;

    assign seed_eff = (seed == 16'h0000) ? LFSR_SEED : seed;

    mc_lfsr16 u_lfsr (
        .clk      (clk),
        .reset    (reset),
        .step_en  (lfsr_step),
        .load     (lfsr_load),
        .load_val (lfsr_load_val),
        .lfsr     (lfsr_cur),
        .fb       (fb)
    );

    always_comb begin
        state_d       = state_q;
        path_valid_d  = path_valid_q;
        path_d        = path_q;
        path_last_d   = path_last_q;
        path_idx_d    = path_idx_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        snap_d        = snap_q;
        step_d        = step_q;
        lfsr_step     = 1'b0;
        lfsr_load     = 1'b0;
        lfsr_load_val = snap_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    lfsr_load     = 1'b1;
                    lfsr_load_val = seed_eff;
                    snap_d        = seed_eff;
                    state_d       = ST_EMIT;
                    path_valid_d  = 1'b1;
                    path_d        = S0;
                    path_last_d   = 1'b0;
                    step_d        = '0;
                    busy_d        = 1'b1;
                end
            end
            ST_EMIT: begin
                if (resend) begin
                    lfsr_load    = 1'b1;
                    path_valid_d = 1'b1;
                    path_d       = S0;
                    path_last_d  = 1'b0;
                    step_d       = '0;
                end else if (step_q == LAST_K) begin
                    state_d      = ST_GAP;
                    path_valid_d = 1'b0;
                    path_last_d  = 1'b0;
                end else begin
                    lfsr_step   = 1'b1;
                    path_d      = mc_step(path_q, fb ? UP : DN);
                    step_d      = step_q + CW'(1);
                    path_last_d = ((step_q + CW'(1)) == LAST_K);
                end
            end
            ST_GAP: begin
                // A resend here replays the path just finished, so the
                // snapshot must not advance.
                if (resend) begin
                    lfsr_load    = 1'b1;
                    state_d      = ST_EMIT;
                    path_valid_d = 1'b1;
                    path_d       = S0;
                    step_d       = '0;
                end else if (path_idx_q == LAST_P) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    path_idx_d   = path_idx_q + IW'(1);
                    snap_d       = lfsr_cur;
                    state_d      = ST_EMIT;
                    path_valid_d = 1'b1;
                    path_d       = S0;
                    step_d       = '0;
                end
            end
            ST_DONE: begin
                state_d    = ST_IDLE;
                path_idx_d = '0;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            path_valid_q <= 1'b0;
            path_q       <= '0;
            path_last_q  <= 1'b0;
            path_idx_q   <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            snap_q       <= LFSR_SEED;
            step_q       <= '0;
        end else begin
            state_q      <= state_d;
            path_valid_q <= path_valid_d;
            path_q       <= path_d;
            path_last_q  <= path_last_d;
            path_idx_q   <= path_idx_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            snap_q       <= snap_d;
            step_q       <= step_d;
        end
    end

    assign path_valid = path_valid_q;
    assign path       = path_q;
    assign path_last  = path_last_q;
    assign path_idx   = path_idx_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_mc_path_gen.sv
// Scoreboard bench for mc_path_gen: the driver pushes cycle-stamped expected
// samples from a reference model, a monitor pops and compares every cycle.
module tb_mc_path_gen;

    localparam int          STEPS = 12;
    localparam int          PATHS = 3;
    localparam logic [11:0] S0_V  = 12'h100;
    localparam logic [11:0] UP_V  = 12'h200;
    localparam logic [11:0] DN_V  = 12'h080;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        resend = 1'b0;
    logic [15:0] seed = 16'h0000;
    logic        path_valid;
    logic [11:0] path;
    logic        path_last;
    logic [1:0]  path_idx;
    logic        busy;
    logic        done;

    logic        s_start = 1'b0;
    logic        s_resend = 1'b0;
    logic [15:0] s_seed = 16'h0000;
    logic        s_valid;
    logic [11:0] s_path;
    logic        s_last;
    logic [0:0]  s_idx;
    logic        s_busy;
    logic        s_done;

    always #5 clk = ~clk;

    mc_path_gen #(.W(12), .FRAC(8), .STEPS(STEPS), .PATHS(PATHS),
                  .S0(S0_V), .UP(UP_V), .DN(DN_V)) u_dut (
        .clk(clk), .reset(reset), .start(start), .resend(resend), .seed(seed),
        .path_valid(path_valid), .path(path), .path_last(path_last),
        .path_idx(path_idx), .busy(busy), .done(done)
    );

    mc_path_gen #(.W(12), .FRAC(8), .STEPS(4), .PATHS(1),
                  .S0(12'h800), .UP(12'h200), .DN(12'h080)) u_sat (
        .clk(clk), .reset(reset), .start(s_start), .resend(s_resend), .seed(s_seed),
        .path_valid(s_valid), .path(s_path), .path_last(s_last),
        .path_idx(s_idx), .busy(s_busy), .done(s_done)
    );

    typedef struct {
        int          cyc;
        logic [11:0] s;
        bit          last;
        int          idx;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    bit   mon_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input logic [11:0] s, input bit last, input int idx);
        exp_t e;
        e.cyc  = cyc + 1;
        e.s    = s;
        e.last = last;
        e.idx  = idx;
        sb.push_back(e);
    endtask

    // Reference step: real-valued price times factor, truncated, clamped.
    function automatic logic [11:0] m_step(input logic [11:0] s, input bit up);
        int unsigned prod;
        int unsigned q;
        prod = int'(s) * int'(up ? UP_V : DN_V);
        q = prod / 256;
        if (q > 4095) q = 4095;
        if (q == 0) q = 1;
        return q[11:0];
    endfunction

    function automatic bit m_fb(input logic [15:0] l);
        return l[15] ^ l[13] ^ l[12] ^ l[10];
    endfunction

    always begin
        exp_t e;
        @(posedge clk);
        #1;
        if (mon_en) begin
            if (sb.size() > 0 && sb[0].cyc == cyc) begin
                e = sb.pop_front();
                chk("sb_valid", {31'b0, path_valid}, 32'd1);
                chk("sb_path", {20'b0, path}, {20'b0, e.s});
                chk("sb_last", {31'b0, path_last}, {31'b0, e.last});
                chk("sb_idx", {30'b0, path_idx}, e.idx);
            end else begin
                chk("idle_valid", {31'b0, path_valid}, 32'd0);
            end
        end
    end

    // One full run; resend_k0 forces a resend on sample k of path 0's first pass.
    task automatic run(input logic [15:0] sd, input int resend_k0, input bit rnd);
        logic [15:0] ml, snap;
        logic [11:0] ms;
        int  k, p, nrs;
        bit  in_gap, finished, k0_used, want;
        $display("run seed=%04h resend_k0=%0d random=%0d", sd, resend_k0, rnd);
        resend = 1'b1;
        @(posedge clk); #3;
        resend = 1'b0;
        ml = (sd == 16'h0000) ? 16'hACE1 : sd;
        snap = ml; ms = S0_V; k = 0; p = 0; nrs = 0;
        in_gap = 0; finished = 0; k0_used = 0;
        seed = sd; start = 1'b1;
        push(S0_V, 0, 0);
        @(posedge clk); #3;
        start = 1'b0;
        while (!finished) begin
            want = (rnd && $urandom_range(0, 19) == 0 && nrs < 4);
            if (!in_gap) begin
                if (!k0_used && p == 0 && k == resend_k0) begin
                    want = 1; k0_used = 1;
                end
                if (want) begin
                    nrs++; resend = 1'b1;
                    ml = snap; ms = S0_V; k = 0;
                    push(S0_V, 0, p);
                end else if (k < STEPS) begin
                    ms = m_step(ms, m_fb(ml));
                    ml = (ml << 1) | {15'b0, m_fb(ml)};
                    k++;
                    push(ms, k == STEPS, p);
                end else begin
                    in_gap = 1;
                end
            end else begin
                chk("gap_busy", {31'b0, busy}, 32'd1);
                if (want) begin
                    nrs++; resend = 1'b1;
                    ml = snap; ms = S0_V; k = 0; in_gap = 0;
                    push(S0_V, 0, p);
                end else if (p == PATHS - 1) begin
                    finished = 1;
                end else begin
                    p++; snap = ml; ms = S0_V; k = 0; in_gap = 0;
                    push(S0_V, 0, p);
                end
            end
            if (rnd && $urandom_range(0, 15) == 0) begin
                start = 1'b1;
                seed = 16'($urandom);
            end
            @(posedge clk); #3;
            resend = 1'b0; start = 1'b0;
        end
        chk("done_pulse", {31'b0, done}, 32'd1);
        chk("done_busy", {31'b0, busy}, 32'd0);
        resend = 1'b1;
        @(posedge clk); #3;
        resend = 1'b0;
        chk("done_clear", {31'b0, done}, 32'd0);
        chk("idle_idx", {30'b0, path_idx}, 32'd0);
        chk("idle_busy", {31'b0, busy}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [11:0] tab [13];
        int n;
        tab = '{12'h100, 12'h080, 12'h040, 12'h020, 12'h010, 12'h008, 12'h004,
                12'h002, 12'h001, 12'h001, 12'h001, 12'h002, 12'h001};

        repeat (3) @(posedge clk);
        #3;
        chk("rst_valid", {31'b0, path_valid}, 32'd0);
        chk("rst_path", {20'b0, path}, 32'd0);
        chk("rst_last", {31'b0, path_last}, 32'd0);
        chk("rst_idx", {30'b0, path_idx}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        reset = 1'b0;
        mon_en = 1'b1;
        @(posedge clk); #3;

        // Known sequence for seed 1, then reset mid-EMIT of path 1.
        $display("directed seed=0001 table");
        seed = 16'h0001; start = 1'b1;
        push(tab[0], 0, 0);
        @(posedge clk); #3;
        start = 1'b0;
        for (int k = 1; k <= STEPS; k++) begin
            push(tab[k], k == STEPS, 0);
            @(posedge clk); #3;
        end
        @(posedge clk); #3;
        chk("tab_gap_busy", {31'b0, busy}, 32'd1);
        push(S0_V, 0, 1);
        @(posedge clk); #3;
        mon_en = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk("async_valid", {31'b0, path_valid}, 32'd0);
        chk("async_path", {20'b0, path}, 32'd0);
        chk("async_idx", {30'b0, path_idx}, 32'd0);
        chk("async_busy", {31'b0, busy}, 32'd0);
        chk("sb_drained", sb.size(), 32'd0);
        @(posedge clk); #3;
        reset = 1'b0;
        mon_en = 1'b1;
        @(posedge clk); #3;

        run(16'h0001, 5, 0);
        run(16'h0000, -1, 0);
        run(16'hACE1, -1, 1);
        for (int i = 0; i < 6; i++) begin
            run(16'($urandom), -1, 1);
        end

        // Saturating instance: 8.0 * 2.0 clamps, then halves to 0x7FF.
        $display("directed saturation seed=0400");
        s_seed = 16'h0400; s_start = 1'b1;
        @(posedge clk); #3;
        s_start = 1'b0;
        chk("sat_s0_valid", {31'b0, s_valid}, 32'd1);
        chk("sat_s0", {20'b0, s_path}, 32'h800);
        @(posedge clk); #3;
        chk("sat_s1", {20'b0, s_path}, 32'hFFF);
        @(posedge clk); #3;
        chk("sat_s2", {20'b0, s_path}, 32'h7FF);
        n = 0;
        while (!s_done && n < 20) begin
            @(posedge clk); #3;
            n++;
        end
        chk("sat_done", {31'b0, s_done}, 32'd1);
        chk("sat_idx", {31'b0, s_idx}, 32'd0);
        chk("sat_busy", {31'b0, s_busy}, 32'd0);
        chk("sat_last_low", {31'b0, s_last}, 32'd0);

        repeat (2) @(posedge clk);
        #3;
        chk("sb_empty", sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
